vqueue_fill_ctrl: RTL and testbench

Write-side sequencer for the video queue FIFO. It fetches one video frame from the framebuffer in fixed-length read bursts on the memory request/response bus and pushes the returned words into the FIFO write port. It refills only while the FIFO reports a low fill level, restarts at each frame start, and runs entirely in the FIFO write-clock domain.

---
 rtl/vqueue_fill_ctrl_pkg.sv | 27 ++
 rtl/vqueue_sync2.sv | 23 ++
 rtl/vqueue_fill_ctrl.sv | 146 ++++++++++++++
 tb/tb_vqueue_fill_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vqueue_fill_ctrl_pkg.sv
// Shared definitions for the video queue write-side sequencer: FSM encoding,
// width helper and parameter-legality predicate.
package vqueue_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } fill_state_t;

    // Bits needed to hold values 0..value-1; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/vqueue_sync2.sv
// Generic two-flop synchroniser for level signals crossing into Clock's domain.
module vqueue_sync2 #(
    parameter int width = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vqueue_fill_ctrl.sv
// Write-side sequencer for the video queue: fetches one frame in fixed bursts
// and pushes returned words into the FIFO while the FIFO reports low fill.
module vqueue_fill_ctrl
    import vqueue_fill_ctrl_pkg::*;
#(
    parameter int addr_width  = 22,
    parameter int burst_len   = 8,
    parameter int frame_words = 24576
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  FrameStart,
    input  logic [addr_width-1:0] BaseAddr,
    input  logic                  Refill,
    output logic                  ReqValid,
    output logic [addr_width-1:0] ReqAddr,
    input  logic                  ReqReady,
    input  logic                  RespValid,
    input  logic [31:0]           RespData,
    output logic                  WrEn,
    output logic [31:0]           Data,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic                  Error
);

    localparam int beat_w = clog2(burst_len);
    localparam int word_w = clog2(frame_words + 1);

    localparam logic [beat_w-1:0] last_beat   = beat_w'(burst_len - 1);
    localparam logic [word_w-1:0] burst_step  = word_w'(burst_len);
    localparam logic [word_w-1:0] frame_total = word_w'(frame_words);

    generate
        if (burst_len < 2 || !is_pow2(burst_len)) begin : g_bad_burst_len
            $error("vqueue_fill_ctrl: burst_len must be a power of 2 and at least 2");
        end
        if (frame_words <= 0 || (frame_words % burst_len) != 0) begin : g_bad_frame_words
            $error("vqueue_fill_ctrl: frame_words must be a positive multiple of burst_len");
        end
    endgenerate

    fill_state_t           state;
    logic [word_w-1:0]     word_cnt;
    logic [beat_w-1:0]     beat_cnt;
    logic [addr_width-1:0] base;
    logic                  restart_pending;
    logic                  refill_s;
    logic [word_w-1:0]     word_cnt_next;

    vqueue_sync2 #(.width(1)) u_refill_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d     (Refill),
        .q     (refill_s)
    );

    assign word_cnt_next = word_cnt + burst_step;

    // NOTE: every register below uses <= so all branches see pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            word_cnt        <= '0;
            beat_cnt        <= '0;
            base            <= '0;
            restart_pending <= 1'b0;
            ReqValid        <= 1'b0;
            ReqAddr         <= '0;
            WrEn            <= 1'b0;
            Data            <= '0;
            Busy            <= 1'b0;
            FrameDone       <= 1'b0;
            Error           <= 1'b0;
        end else begin
            WrEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (RespValid) begin
                        Error <= 1'b1;
                    end
                    if (FrameStart) begin
                        word_cnt        <= '0;
                        FrameDone       <= 1'b0;
                        base            <= BaseAddr;
                        restart_pending <= 1'b0;
                    end else if (Enable && refill_s && !FrameDone && !restart_pending) begin
                        state    <= REQ;
                        ReqValid <= 1'b1;
                        ReqAddr  <= base + addr_width'(word_cnt);
                        Busy     <= 1'b1;
                    end
                end

                REQ: begin
                    // Enable is ignored here: an issued request is never withdrawn.
                    if (RespValid) begin
                        Error <= 1'b1;
                    end
                    if (FrameStart) begin
                        restart_pending <= 1'b1;
                    end
                    if (ReqReady) begin
                        ReqValid <= 1'b0;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (FrameStart) begin
                        restart_pending <= 1'b1;
                    end
                    if (RespValid) begin
                        WrEn     <= 1'b1;
                        Data     <= RespData;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == last_beat) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            // A deferred restart lands on the IDLE entry edge and
                            // discards this burst's contribution to the frame count.
                            if (restart_pending || FrameStart) begin
                                word_cnt        <= '0;
                                FrameDone       <= 1'b0;
                                base            <= BaseAddr;
                                restart_pending <= 1'b0;
                            end else begin
                                word_cnt  <= word_cnt_next;
                                FrameDone <= (word_cnt_next == frame_total);
                            end
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    ReqValid <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vqueue_fill_ctrl.sv
// Scoreboard bench for vqueue_fill_ctrl: a memory responder feeds bursts, a
// frame-level model predicts addresses, a monitor checks every FIFO write.
module tb_vqueue_fill_ctrl;

    localparam int AW = 22;
    localparam int BL = 8;
    localparam int FW = 32;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Enable;
    logic          FrameStart;
    logic [AW-1:0] BaseAddr;
    logic          Refill;
    logic          ReqValid;
    logic [AW-1:0] ReqAddr;
    logic          ReqReady;
    logic          RespValid;
    logic [31:0]   RespData;
    logic          WrEn;
    logic [31:0]   Data;
    logic          Busy;
    logic          FrameDone;
    logic          Error;

    vqueue_fill_ctrl #(
        .addr_width  (AW),
        .burst_len   (BL),
        .frame_words (FW)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .FrameStart (FrameStart),
        .BaseAddr   (BaseAddr),
        .Refill     (Refill),
        .ReqValid   (ReqValid),
        .ReqAddr    (ReqAddr),
        .ReqReady   (ReqReady),
        .RespValid  (RespValid),
        .RespData   (RespData),
        .WrEn       (WrEn),
        .Data       (Data),
        .Busy       (Busy),
        .FrameDone  (FrameDone),
        .Error      (Error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    wr_exp_t exp_wr[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int wr_seen = 0;
    int pending_bursts = 0;
    int beats_left = 0;
    int gap_pct = 0;
    bit burst_active = 0;
    bit abort = 0;
    bit inject = 0;

    // Frame-level reference: base of current frame, words already fetched,
    // and a restart deferred until the in-flight burst ends.
    longint m_base = 0;
    int     m_words = 0;
    bit     m_pend = 0;
    longint m_pend_base = 0;

    int            w0, n, lat;
    logic [AW-1:0] a0;
    bit            ok;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] model_next_addr();
        return (m_base + m_words) % (64'd1 << AW);
    endfunction

    function automatic bit model_done();
        return m_words == FW;
    endfunction

    task automatic model_frame_start(input longint b);
        if (burst_active) begin
            m_pend      = 1;
            m_pend_base = b;
        end else begin
            m_base  = b;
            m_words = 0;
        end
    endtask

    task automatic model_burst_done();
        m_words += BL;
        if (m_pend) begin
            m_base  = m_pend_base;
            m_words = 0;
            m_pend  = 0;
        end
        burst_active = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_frame(input logic [AW-1:0] b);
        BaseAddr   = b;
        FrameStart = 1'b1;
        model_frame_start(longint'(b));
        tick();
        FrameStart = 1'b0;
    endtask

    task automatic wait_wr(input int target, input string name);
        int k;
        k = 0;
        while (wr_seen < target && k < 500) begin
            @(negedge Clock);
            #1;
            k++;
        end
        check(name, wr_seen >= target, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!FrameDone && k < 2000) begin
            @(negedge Clock);
            #1;
            k++;
        end
        check(name, FrameDone, 1'b1);
    endtask

    task automatic expect_no_req(input int cycles, input string name);
        bit quiet;
        quiet = 1;
        repeat (cycles) begin
            @(negedge Clock);
            #1;
            if (ReqValid) quiet = 0;
        end
        check(name, quiet, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, ReqValid, 0);
        check({tag, "_req_addr"}, ReqAddr, 0);
        check({tag, "_wr_en"}, WrEn, 0);
        check({tag, "_data"}, Data, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_frame_done"}, FrameDone, 0);
        check({tag, "_error"}, Error, 0);
    endtask

    // Monitor: FIFO writes against the scoreboard, requests against the model.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                if (WrEn) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", WrEn, 1'b0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_data", Data, e.data);
                        check("wr_latency", cyc, e.cyc);
                    end
                end
                if (ReqValid && ReqReady) begin
                    if (model_done()) begin
                        check("req_after_done", ReqValid, 1'b0);
                    end else begin
                        check("req_addr", ReqAddr, model_next_addr());
                    end
                    burst_active = 1;
                    pending_bursts++;
                end
            end
        end
    end

    // Memory responder: returns BL words per accepted request with random gaps.
    initial begin
        RespValid = 1'b0;
        RespData  = '0;
        forever begin
            tick();
            RespValid = 1'b0;
            if (Reset || abort) begin
                beats_left = 0;
            end else begin
                if (beats_left == 0 && pending_bursts > 0) begin
                    pending_bursts--;
                    beats_left = BL;
                end
                if (beats_left > 0 && $urandom_range(99) >= gap_pct) begin
                    RespValid = 1'b1;
                    RespData  = $urandom;
                    exp_wr.push_back('{data: RespData, cyc: cyc + 1});
                    beats_left--;
                    if (beats_left == 0) model_burst_done();
                end else if (inject && beats_left == 0) begin
                    RespValid = 1'b1;
                    RespData  = $urandom;
                    inject    = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        Enable     = 1'b0;
        FrameStart = 1'b0;
        Refill     = 1'b0;
        ReqReady   = 1'b1;
        BaseAddr   = '0;
        repeat (3) @(negedge Clock);
        check_all_zero("reset");
        tick();
        Reset = 1'b0;

        // Full frame with continuous responses.
        Refill = 1'b1;
        repeat (3) tick();
        w0 = wr_seen;
        pulse_frame(22'h001000);
        Enable = 1'b1;
        wait_done("t1_done");
        check("t1_wr_count", wr_seen - w0, FW);
        check("t1_sb_drained", exp_wr.size(), 0);
        expect_no_req(20, "t1_no_req_after_done");
        check("t1_busy_idle", Busy, 0);

        // Refill drops mid-burst, then returns.
        tick();
        w0 = wr_seen;
        pulse_frame(22'h004000);
        wait_wr(w0 + 1, "t2_first_beat");
        tick();
        Refill = 1'b0;
        wait_wr(w0 + BL, "t2_burst_finished");
        expect_no_req(10, "t2_no_req_refill_low");
        tick();
        Refill = 1'b1;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (ReqValid && lat < 0) lat = i;
        end
        check("t2_refill_latency", lat, 3);

        // Restart during beat 3 of the frame's last burst.
        wait_wr(w0 + FW - BL + 3, "t3_beat3");
        tick();
        pulse_frame(22'h002000);
        wait_wr(w0 + FW, "t3_burst_finished");
        check("t3_frame_done_cleared", FrameDone, model_done());
        check("t3_wr_count", wr_seen - w0, FW);
        wait_done("t3_new_frame_done");
        check("t3_sb_drained", exp_wr.size(), 0);

        // Request stalled by ReqReady while Enable drops.
        tick();
        ReqReady = 1'b0;
        w0 = wr_seen;
        pulse_frame(22'h003000);
        n = 0;
        while (!ReqValid && n < 20) begin
            @(negedge Clock);
            #1;
            n++;
        end
        check("t4_req_seen", ReqValid, 1);
        a0 = ReqAddr;
        check("t4_req_addr", a0, 22'h003000);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) Enable = 1'b0;
            @(negedge Clock);
            if (!ReqValid || ReqAddr !== a0 || !Busy) ok = 0;
        end
        check("t4_req_stable", ok, 1);
        tick();
        ReqReady = 1'b1;
        wait_wr(w0 + BL, "t4_burst_finished");
        expect_no_req(20, "t4_no_req_enable_low");
        check("t4_frame_not_done", FrameDone, model_done());
        check("t4_busy_idle", Busy, 0);

        // Address wrap at the top of the address space.
        tick();
        pulse_frame(22'h3FFFF8);
        Enable = 1'b1;
        w0 = wr_seen;
        wait_done("t5_done");
        check("t5_wr_count", wr_seen - w0, FW);
        check("t5_sb_drained", exp_wr.size(), 0);

        // Randomised frames: stalls, gaps, Refill and Enable toggling.
        gap_pct = 30;
        for (int f = 0; f < 3; f++) begin
            tick();
            w0 = wr_seen;
            pulse_frame(AW'($urandom));
            n = 0;
            while (!FrameDone && n < 3000) begin
                tick();
                ReqReady = 1'($urandom_range(1));
                Enable   = ($urandom_range(7) != 0);
                if (n % 5 == 0) Refill = ($urandom_range(3) != 0);
                @(negedge Clock);
                #1;
                n++;
            end
            check("rand_done", FrameDone, 1);
            check("rand_wr_count", wr_seen - w0, FW);
            check("rand_sb_drained", exp_wr.size(), 0);
            tick();
            ReqReady = 1'b1;
            Enable   = 1'b1;
            Refill   = 1'b1;
        end
        gap_pct = 0;

        // Stray response while idle.
        tick();
        inject = 1;
        ok = 1;
        repeat (6) begin
            @(negedge Clock);
            #1;
            if (WrEn) ok = 0;
        end
        check("t6_no_wren_spurious", ok, 1);
        check("t6_error_set", Error, 1);

        // Asynchronous reset in the middle of a burst.
        tick();
        w0 = wr_seen;
        pulse_frame(22'h005000);
        wait_wr(w0 + 3, "t6_mid_burst");
        #2 Reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        abort = 1;
        repeat (2) @(posedge Clock);
        #1;
        exp_wr.delete();
        pending_bursts = 0;
        burst_active   = 0;
        Enable         = 1'b0;
        m_base         = 0;
        m_words        = 0;
        m_pend         = 0;
        abort          = 0;
        tick();
        Reset = 1'b0;
        expect_no_req(10, "t6_idle_after_reset");
        check("t6_error_stays_clear", Error, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
